simon_btn_encoder: RTL and testbench

- Producer side of the Simon button interface.
- Takes four raw, bouncy, asynchronous push-buttons and produces one clean event per physical press.
- Each event is `btn_valid` high for exactly one `clk_tick` cycle, with a 2-bit button index on `btn_val`; the game FSM consumes these directly.
- Handles synchronisation, press/release debounce, multi-press rejection and gating while the game is not accepting input.

---
 rtl/simon_btn_encoder_if.sv | 18 +
 rtl/simon_btn_encoder.sv | 142 ++++++++++++++
 tb/tb_simon_btn_encoder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_btn_encoder_if.sv
// Button event bus between the button encoder (producer) and the game FSM (consumer).
interface simon_btn_encoder_if;
  logic       btn_valid;
  logic [1:0] btn_val;
  logic       multi_err;

  modport master (
    output btn_valid,
    output btn_val,
    output multi_err
  );

  modport slave (
    input btn_valid,
    input btn_val,
    input multi_err
  );
endinterface

// File: rtl/simon_btn_encoder.sv
// Simon button encoder: synchronises four raw push-buttons, debounces press and
// release, rejects simultaneous presses and emits one event per physical press.
module simon_btn_encoder #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned RELEASE_TICKS  = 3
) (
  input  logic                       clk_tick,
  input  logic                       reset,
  input  logic [3:0]                 btn_raw,
  input  logic                       enable,
  simon_btn_encoder_if.master        btn_if,
  output logic [2:0]                 state
);

  localparam int unsigned MAX_TICKS = (DEBOUNCE_TICKS > RELEASE_TICKS) ? DEBOUNCE_TICKS
                                                                       : RELEASE_TICKS;
  localparam int unsigned CNT_W = $clog2(MAX_TICKS) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] RL_LAST = CNT_W'(RELEASE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESS_DB   = 2'd1,
    S_HOLD       = 2'd2,
    S_RELEASE_DB = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]   sync_q, sync_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [1:0]                    cand_q, cand_d;
  logic                          btn_valid_q, btn_valid_d;
  logic [1:0]                    btn_val_q, btn_val_d;
  logic                          multi_err_q, multi_err_d;

  logic [3:0] sync;
  logic       sync_onehot;
  logic       sync_multi;
  logic [1:0] hot_idx;
  logic [3:0] cand_mask;

  assign sync = sync_q[SYNC_STAGES-1];

  // Decode the synchronised button vector: one-hot / multiple / index of set bit.
  always_comb begin
    hot_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync[i]) hot_idx = 2'(i);
    end
    sync_onehot = $onehot(sync);
    sync_multi  = (sync != '0) && !sync_onehot;
    cand_mask   = 4'b0001 << cand_q;
  end

  // Next-state logic: synchroniser shift plus press/hold/release FSM with enable lockout.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], btn_raw};
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    btn_valid_d = 1'b0;
    btn_val_d   = btn_val_q;
    multi_err_d = 1'b0;

    if (!enable) begin
      // Parking in S_HOLD means a press must be fully released before it can count.
      state_d = S_HOLD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (sync_onehot) begin
            cand_d  = hot_idx;
            cnt_d   = '0;
            state_d = S_PRESS_DB;
          end else if (sync_multi) begin
            multi_err_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
        S_PRESS_DB: begin
          if (sync == cand_mask) begin
            if (cnt_q == DB_LAST) begin
              btn_valid_d = 1'b1;
              btn_val_d   = cand_q;
              state_d     = S_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HOLD: begin
          if (sync == '0) begin
            cnt_d   = '0;
            state_d = S_RELEASE_DB;
          end
        end
        S_RELEASE_DB: begin
          if (sync == '0) begin
            if (cnt_q == RL_LAST) begin
              state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // All state and outputs registered; asynchronous active-high clear.
  always_ff @(posedge clk_tick or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      btn_valid_q <= 1'b0;
      btn_val_q   <= '0;
      multi_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      btn_valid_q <= btn_valid_d;
      btn_val_q   <= btn_val_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign btn_if.btn_valid = btn_valid_q;
  assign btn_if.btn_val   = btn_val_q;
  assign btn_if.multi_err = multi_err_q;
  assign state            = {1'b0, state_q};

endmodule

// File: tb/tb_simon_btn_encoder.sv
// Testbench for simon_btn_encoder: directed vector tables, an async-reset
// sequence, and a randomized run against a run-length reference model.
module tb_simon_btn_encoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DB   = 3;
  localparam int unsigned RL   = 3;

  logic       clk_tick = 1'b0;
  logic       reset    = 1'b1;
  logic       enable   = 1'b1;
  logic [3:0] btn_raw  = '0;
  logic [2:0] state;

  simon_btn_encoder_if bus ();

  simon_btn_encoder #(
    .SYNC_STAGES   (SYNC),
    .DEBOUNCE_TICKS(DB),
    .RELEASE_TICKS (RL)
  ) dut (
    .clk_tick(clk_tick),
    .reset   (reset),
    .btn_raw (btn_raw),
    .enable  (enable),
    .btn_if  (bus),
    .state   (state)
  );

  always #5 clk_tick = ~clk_tick;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] raw;
    logic       en;
    logic       valid;
    logic [1:0] val;
    logic       merr;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [3:0] raw, input logic en, input logic v,
                     input logic [1:0] val, input logic m, input logic [2:0] st);
    repeat (n) tbl.push_back('{raw, en, v, val, m, st});
  endtask

  // Each row: drive inputs, take one edge, sample 1 time unit later.
  task automatic run_table(input string name);
    foreach (tbl[i]) begin
      btn_raw = tbl[i].raw;
      enable  = tbl[i].en;
      @(posedge clk_tick);
      #1;
      check({name, ".btn_valid"}, i, {3'b0, bus.btn_valid}, {3'b0, tbl[i].valid});
      check({name, ".btn_val"},   i, {2'b0, bus.btn_val},   {2'b0, tbl[i].val});
      check({name, ".multi_err"}, i, {3'b0, bus.multi_err}, {3'b0, tbl[i].merr});
      check({name, ".state"},     i, {1'b0, state},         {1'b0, tbl[i].st});
    end
    tbl.delete();
  endtask

  // ---------------- reference model ----------------
  // Works on the sample stream the debouncer sees: a press is accepted once the
  // same single button has been seen DB+1 times in a row from an armed state;
  // re-arming needs RL+1 consecutive all-released samples.
  logic [3:0]  pipe[$];
  bit          locked;
  int unsigned zero_run;
  int unsigned press_run;
  logic [1:0]  press_btn;
  logic [1:0]  m_val;
  bit          m_valid, m_merr;
  int          m_pulses;

  task automatic model_reset();
    pipe.delete();
    for (int unsigned i = 0; i < SYNC; i++) pipe.push_back(4'b0);
    locked = 0; zero_run = 0; press_run = 0; press_btn = '0;
    m_val = '0; m_valid = 0; m_merr = 0;
  endtask

  task automatic model_step(input logic [3:0] raw, input logic en);
    logic [3:0] s;
    pipe.push_back(raw);
    s = pipe.pop_front();
    m_valid = 0;
    m_merr  = 0;
    if (!en) begin
      locked = 1; zero_run = 0; press_run = 0;
    end else if (locked) begin
      if (s == 4'b0) begin
        zero_run++;
        if (zero_run == RL + 1) locked = 0;
      end else begin
        zero_run = 0;
      end
    end else if (press_run == 0) begin
      if ($countones(s) == 1) begin
        press_btn = 2'($clog2(s));
        press_run = 1;
      end else if ($countones(s) > 1) begin
        m_merr = 1; locked = 1; zero_run = 0;
      end
    end else if (s == (4'b0001 << press_btn)) begin
      press_run++;
      if (press_run == DB + 1) begin
        m_valid = 1; m_val = press_btn; m_pulses++;
        locked = 1; zero_run = 0; press_run = 0;
      end
    end else begin
      press_run = 0;
    end
  endtask

  logic [3:0] multis[5] = '{4'b0011, 4'b0101, 4'b1100, 4'b1111, 4'b0110};

  initial begin
    int unsigned seg_left;
    logic [3:0]  seg_raw;
    logic        seg_en;
    int unsigned r;

    // Reset state
    repeat (2) @(posedge clk_tick);
    #1;
    check("rst.btn_valid", 0, {3'b0, bus.btn_valid}, 4'h0);
    check("rst.btn_val",   0, {2'b0, bus.btn_val},   4'h0);
    check("rst.multi_err", 0, {3'b0, bus.multi_err}, 4'h0);
    check("rst.state",     0, {1'b0, state},         4'h0);
    reset = 1'b0;

    // Clean press of button 2
    add(2,  4'b0100, 1, 0, 2'd0, 0, 3'd0);
    add(3,  4'b0100, 1, 0, 2'd0, 0, 3'd1);
    add(1,  4'b0100, 1, 1, 2'd2, 0, 3'd2);
    add(14, 4'b0100, 1, 0, 2'd2, 0, 3'd2);
    add(2,  4'b0000, 1, 0, 2'd2, 0, 3'd2);
    add(3,  4'b0000, 1, 0, 2'd2, 0, 3'd3);
    add(3,  4'b0000, 1, 0, 2'd2, 0, 3'd0);
    run_table("clean");

    // Press bounce
    add(2, 4'b0100, 1, 0, 2'd2, 0, 3'd0);
    add(1, 4'b0000, 1, 0, 2'd2, 0, 3'd1);
    add(1, 4'b0100, 1, 0, 2'd2, 0, 3'd1);
    add(1, 4'b0100, 1, 0, 2'd2, 0, 3'd0);
    add(3, 4'b0100, 1, 0, 2'd2, 0, 3'd1);
    add(1, 4'b0100, 1, 1, 2'd2, 0, 3'd2);
    add(3, 4'b0100, 1, 0, 2'd2, 0, 3'd2);
    add(2, 4'b0000, 1, 0, 2'd2, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd2, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd2, 0, 3'd0);
    run_table("press_bounce");

    // Enable lockout: button held across enable rise never fires
    add(4, 4'b0001, 0, 0, 2'd2, 0, 3'd2);
    add(4, 4'b0001, 1, 0, 2'd2, 0, 3'd2);
    add(2, 4'b0000, 1, 0, 2'd2, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd2, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd2, 0, 3'd0);
    add(2, 4'b0001, 1, 0, 2'd2, 0, 3'd0);
    add(3, 4'b0001, 1, 0, 2'd2, 0, 3'd1);
    add(1, 4'b0001, 1, 1, 2'd0, 0, 3'd2);
    add(1, 4'b0001, 1, 0, 2'd0, 0, 3'd2);
    add(2, 4'b0000, 1, 0, 2'd0, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd0, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd0, 0, 3'd0);
    run_table("enable_lock");

    // Multi-press then a clean press of button 3
    add(2, 4'b0011, 1, 0, 2'd0, 0, 3'd0);
    add(1, 4'b0011, 1, 0, 2'd0, 1, 3'd2);
    add(1, 4'b0011, 1, 0, 2'd0, 0, 3'd2);
    add(2, 4'b0000, 1, 0, 2'd0, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd0, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd0, 0, 3'd0);
    add(2, 4'b1000, 1, 0, 2'd0, 0, 3'd0);
    add(3, 4'b1000, 1, 0, 2'd0, 0, 3'd1);
    add(1, 4'b1000, 1, 1, 2'd3, 0, 3'd2);
    add(2, 4'b0000, 1, 0, 2'd3, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd3, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd3, 0, 3'd0);
    run_table("multi");

    // Release bounce after press of button 3
    add(2, 4'b1000, 1, 0, 2'd3, 0, 3'd0);
    add(3, 4'b1000, 1, 0, 2'd3, 0, 3'd1);
    add(1, 4'b1000, 1, 1, 2'd3, 0, 3'd2);
    add(2, 4'b1000, 1, 0, 2'd3, 0, 3'd2);
    add(1, 4'b0000, 1, 0, 2'd3, 0, 3'd2);
    add(1, 4'b1000, 1, 0, 2'd3, 0, 3'd2);
    add(1, 4'b0000, 1, 0, 2'd3, 0, 3'd3);
    add(1, 4'b0000, 1, 0, 2'd3, 0, 3'd2);
    add(3, 4'b0000, 1, 0, 2'd3, 0, 3'd3);
    add(2, 4'b0000, 1, 0, 2'd3, 0, 3'd0);
    run_table("release_bounce");

    // Async reset while debouncing button 1, then the held button fires again
    add(2, 4'b0010, 1, 0, 2'd3, 0, 3'd0);
    add(2, 4'b0010, 1, 0, 2'd3, 0, 3'd1);
    run_table("pre_reset");
    #1;
    reset = 1'b1;
    #1;
    check("async_rst.btn_valid", 0, {3'b0, bus.btn_valid}, 4'h0);
    check("async_rst.btn_val",   0, {2'b0, bus.btn_val},   4'h0);
    check("async_rst.multi_err", 0, {3'b0, bus.multi_err}, 4'h0);
    check("async_rst.state",     0, {1'b0, state},         4'h0);
    @(posedge clk_tick);
    #1;
    reset = 1'b0;
    add(2, 4'b0010, 1, 0, 2'd0, 0, 3'd0);
    add(3, 4'b0010, 1, 0, 2'd0, 0, 3'd1);
    add(1, 4'b0010, 1, 1, 2'd1, 0, 3'd2);
    add(1, 4'b0010, 1, 0, 2'd1, 0, 3'd2);
    run_table("post_reset");

    // Randomized run against the reference model
    reset   = 1'b1;
    btn_raw = '0;
    enable  = 1'b1;
    @(posedge clk_tick);
    #1;
    reset = 1'b0;
    model_reset();
    m_pulses = 0;
    seg_left = 0;
    seg_raw  = '0;
    seg_en   = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (seg_left == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4) begin
          seg_raw  = 4'b0;
          seg_left = $urandom_range(1, 8);
        end else if (r < 8) begin
          seg_raw  = 4'b0001 << $urandom_range(0, 3);
          seg_left = $urandom_range(1, 12);
        end else if (r == 8) begin
          seg_raw  = multis[$urandom_range(0, 4)];
          seg_left = $urandom_range(1, 6);
        end else begin
          seg_raw  = 4'(1 << $urandom_range(0, 3)) | 4'(1 << $urandom_range(0, 3));
          seg_left = 1;
        end
        seg_en = ($urandom_range(0, 9) != 0);
      end
      seg_left--;
      btn_raw = seg_raw;
      enable  = seg_en;
      model_step(seg_raw, seg_en);
      @(posedge clk_tick);
      #1;
      check("rand.btn_valid", c, {3'b0, bus.btn_valid}, {3'b0, m_valid});
      check("rand.btn_val",   c, {2'b0, bus.btn_val},   {2'b0, m_val});
      check("rand.multi_err", c, {3'b0, bus.multi_err}, {3'b0, m_merr});
    end
    checks++;
    if (m_pulses < 3) begin
      failures++;
      $display("FAIL rand.pulse_count got=%0d expected>=3", m_pulses);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
